// File: rtl/ex_bacdctx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_bacdctx                                                   |
// | Description : slink transmit byte-width converter. Pulls 18-bit framed     |
// |               words from the transmit PFIFO (rdreq/empty, 1-cycle read     |
// |               latency) and serializes them high byte first onto the 8-bit  |
// |               MAC transmit stream with sop/eop and valid/ready.            |
// | Options     : EX_BACDCTX_IPG_EN - when defined, IPG_CYCLES idle cycles are |
// |               inserted after every accepted eop byte.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_bacdctx #(
  parameter int IPG_CYCLES = 12
) (
  input  logic        clk_125m,
  input  logic        rst_125m,
  input  logic        mm_slink_empty,
  output logic        slink_mm_rdreq,
  input  logic        mm_slink_dval,
  input  logic [17:0] mm_slink_data,
  input  logic        mactx_txfifo_rdy,
  output logic        mactx_txfifo_dval,
  output logic        mactx_txfifo_sop,
  output logic        mactx_txfifo_eop,
  output logic [7:0]  mactx_txfifo_data,
  output logic        slink_tx_err
);

  localparam logic [1:0] TAG_SOP  = 2'b10;
  localparam logic [1:0] TAG_EOP2 = 2'b01;
  localparam logic [1:0] TAG_EOP1 = 2'b11;

  // IDLE also acts as the high-byte phase, so the first byte of a word is
  // loaded into the output stage in the same cycle the word becomes visible.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

`ifdef EX_BACDCTX_IPG_EN
  localparam state_t     ST_AFTER_EOP = ST_GAP;
  localparam logic [7:0] GAP_LAST     = 8'(IPG_CYCLES - 1);
`else
  localparam state_t     ST_AFTER_EOP = ST_IDLE;
`endif

  if (IPG_CYCLES < 1 || IPG_CYCLES > 255) begin : g_ipg_range_chk
    $error("ex_bacdctx: IPG_CYCLES must be in 1..255");
  end

  // Word buffer (2 entries)
  logic [1:0][17:0] buf_q, buf_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             outstanding_q, outstanding_d;

  // Serializer / packet tracking
  state_t           state_q, state_d;
  logic             in_pkt_q, in_pkt_d;
`ifdef EX_BACDCTX_IPG_EN
  logic [7:0]       gap_cnt_q, gap_cnt_d;
`endif

  // Registered output stage
  logic             dval_q, dval_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;

  logic             rdreq;
  logic             wr_en;
  logic             pop;
  logic             load_en;
  logic             hi_phase;
  logic             head_vld;
  logic [17:0]      head;
  logic [1:0]       head_tag;

  assign head     = buf_q[rd_ptr_q];
  assign head_tag = head[17:16];
  assign head_vld = (count_q != 2'd0);
  assign load_en  = !dval_q || mactx_txfifo_rdy;
  assign wr_en    = mm_slink_dval && (count_q != 2'd2);

  // Read request: room for the word plus any read already in flight; held low in reset
  assign rdreq = rst_125m && !mm_slink_empty &&
                 (({1'b0, count_q} + {2'b00, outstanding_q}) < 3'd2);

  // Word buffer pointer/occupancy update; a simultaneous push and pop keeps occupancy
  always_comb begin
    buf_d         = buf_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = rdreq;
    if (wr_en) begin
      buf_d[wr_ptr_q] = mm_slink_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Serializer next state, packet tracking, framing errors and output-stage load
  always_comb begin
    state_d  = state_q;
    in_pkt_d = in_pkt_q;
    pop      = 1'b0;
    err_d    = 1'b0;
    dval_d   = dval_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    data_d   = data_q;
    hi_phase = (state_q == ST_IDLE);
`ifdef EX_BACDCTX_IPG_EN
    gap_cnt_d = gap_cnt_q;
    // Gap cycles are only those with nothing on the output; the last one
    // also serves as the high-byte phase so the gap is exactly IPG_CYCLES.
    if (state_q == ST_GAP && !dval_q) begin
      if (gap_cnt_q == GAP_LAST) begin
        gap_cnt_d = 8'd0;
        state_d   = ST_IDLE;
        hi_phase  = 1'b1;
      end else begin
        gap_cnt_d = gap_cnt_q + 8'd1;
      end
    end
`endif

    if (load_en) begin
      dval_d = 1'b0;
      sop_d  = 1'b0;
      eop_d  = 1'b0;
    end

    if (hi_phase && head_vld) begin
      if (head_tag != TAG_SOP && !in_pkt_q) begin
        // Orphan word outside a packet: discard it and flag
        pop   = 1'b1;
        err_d = 1'b1;
      end else if (load_en) begin
        dval_d = 1'b1;
        data_d = head[15:8];
        sop_d  = (head_tag == TAG_SOP);
        eop_d  = (head_tag == TAG_EOP1);
        if (head_tag == TAG_SOP) begin
          in_pkt_d = 1'b1;
          err_d    = in_pkt_q;
        end
        if (head_tag == TAG_EOP1) begin
          pop      = 1'b1;
          in_pkt_d = 1'b0;
          state_d  = ST_AFTER_EOP;
        end else begin
          state_d  = ST_LO;
        end
      end
    end else if (state_q == ST_LO && load_en) begin
      dval_d = 1'b1;
      data_d = head[7:0];
      eop_d  = (head_tag == TAG_EOP2);
      pop    = 1'b1;
      if (head_tag == TAG_EOP2) begin
        in_pkt_d = 1'b0;
        state_d  = ST_AFTER_EOP;
      end else begin
        state_d  = ST_IDLE;
      end
    end
  end

  // State registers; reset discards buffered and in-flight words
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      buf_q         <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      outstanding_q <= 1'b0;
      state_q       <= ST_IDLE;
      in_pkt_q      <= 1'b0;
`ifdef EX_BACDCTX_IPG_EN
      gap_cnt_q     <= 8'd0;
`endif
      dval_q        <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      data_q        <= 8'd0;
      err_q         <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      state_q       <= state_d;
      in_pkt_q      <= in_pkt_d;
`ifdef EX_BACDCTX_IPG_EN
      gap_cnt_q     <= gap_cnt_d;
`endif
      dval_q        <= dval_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      data_q        <= data_d;
      err_q         <= err_d;
    end
  end

  assign slink_mm_rdreq    = rdreq;
  assign mactx_txfifo_dval = dval_q;
  assign mactx_txfifo_sop  = sop_q;
  assign mactx_txfifo_eop  = eop_q;
  assign mactx_txfifo_data = data_q;
  assign slink_tx_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_bacdctx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_bacdctx                                                |
// | Description : Scoreboard bench for ex_bacdctx with a word-level packet     |
// |               model, PFIFO responder and randomized ready/underrun.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ex_bacdctx;

  localparam int IPG = 12;
`ifdef EX_BACDCTX_IPG_EN
  localparam int EXP_GAP = IPG;
`else
  localparam int EXP_GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        empty = 1'b1;
  logic        rdreq;
  logic        dval_in = 1'b0;
  logic [17:0] data_in = '0;
  logic        rdy = 1'b1;
  logic        tx_dval, tx_sop, tx_eop, tx_err;
  logic [7:0]  tx_data;

  ex_bacdctx #(.IPG_CYCLES(IPG)) dut (
    .clk_125m          (clk),
    .rst_125m          (rst_n),
    .mm_slink_empty    (empty),
    .slink_mm_rdreq    (rdreq),
    .mm_slink_dval     (dval_in),
    .mm_slink_data     (data_in),
    .mactx_txfifo_rdy  (rdy),
    .mactx_txfifo_dval (tx_dval),
    .mactx_txfifo_sop  (tx_sop),
    .mactx_txfifo_eop  (tx_eop),
    .mactx_txfifo_data (tx_data),
    .slink_tx_err      (tx_err)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] pfifo[$];
  logic [9:0]  exp_q[$];        // {sop, eop, byte}
  bit          model_in_pkt = 1'b0;
  int          err_exp = 0;
  int          err_seen = 0;
  int          acc_bytes = 0;
  int          rdy_mode = 0;
  int          fall_cyc = 0;
  int          eop_cyc = 0;
  bit          chk_lat = 1'b0;
  bit          chk_gap = 1'b0;
  bit          gap_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word-level framing rules, expected bytes pushed as stimulus is issued
  task automatic push_word(input logic [1:0] tag, input logic [15:0] d);
    pfifo.push_back({tag, d});
    if (tag == 2'b10) begin
      if (model_in_pkt) err_exp++;
      exp_q.push_back({2'b10, d[15:8]});
      exp_q.push_back({2'b00, d[7:0]});
      model_in_pkt = 1'b1;
    end else if (!model_in_pkt) begin
      err_exp++;
    end else if (tag == 2'b11) begin
      exp_q.push_back({2'b01, d[15:8]});
      model_in_pkt = 1'b0;
    end else begin
      exp_q.push_back({2'b00, d[15:8]});
      exp_q.push_back({1'b0, tag == 2'b01, d[7:0]});
      if (tag == 2'b01) model_in_pkt = 1'b0;
    end
  endtask

  task automatic push_pkt(input int len, input bit with_eop, input int max_gap);
    int n;
    logic [15:0] d;
    n = 0;
    while (n < len) begin
      d = 16'($urandom);
      if (max_gap > 0 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, max_gap)) @(posedge clk);
        #2;
      end
      if (n == 0)                   push_word(2'b10, d);
      else if (!with_eop)           push_word(2'b00, d);
      else if (len - n == 1)        push_word(2'b11, d);
      else if (len - n == 2)        push_word(2'b01, d);
      else                          push_word(2'b00, d);
      n += 2;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((pfifo.size() != 0 || exp_q.size() != 0) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size() == 0 && pfifo.size() == 0), 32'd1);
    repeat (EXP_GAP + 8) @(posedge clk);
    #2;
  endtask

  // MAC ready generator: 0 = always ready, 1 = pattern 1,0,0, 2 = random
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       rdy = (k % 3 == 0);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      k++;
    end
  end

  // PFIFO responder: data one cycle after an accepted read request
  initial begin
    bit          pend;
    bit          r;
    logic [17:0] pw;
    pend = 1'b0;
    pw   = '0;
    forever begin
      @(posedge clk);
      #1;
      dval_in = pend;
      data_in = pw;
      if (empty && pfifo.size() != 0) fall_cyc = cyc;
      empty = (pfifo.size() == 0);
      @(negedge clk);
      r    = rdreq;
      pend = 1'b0;
      if (r) begin
        check("rdreq_while_empty", 32'(empty), 32'd0);
        if (pfifo.size() != 0) begin
          pw   = pfifo.pop_front();
          pend = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted byte
  initial begin
    logic [9:0] got;
    logic [9:0] want;
    logic [9:0] hold_word;
    bit         hold_valid;
    hold_valid = 1'b0;
    hold_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_valid = 1'b0;
      end else begin
        if (tx_err) err_seen++;
        if (hold_valid)
          check("stall_hold", 32'({tx_dval, tx_sop, tx_eop, tx_data}), 32'({1'b1, hold_word}));
        hold_valid = 1'b0;
        if (tx_dval) begin
          got = {tx_sop, tx_eop, tx_data};
          if (rdy) begin
            acc_bytes++;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_byte: got %0h expected no byte (cycle %0d)", got, cyc);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                miscompares++;
                $display("FAIL byte: got %0h expected %0h (cycle %0d)", got, want, cyc);
              end
            end
            if (tx_sop && gap_armed) begin
              check("ipg_gap", 32'(cyc - eop_cyc - 1), 32'(EXP_GAP));
              gap_armed = 1'b0;
              chk_gap   = 1'b0;
            end
            if (tx_sop && chk_lat) begin
              check("first_byte_latency", 32'(cyc - fall_cyc), 32'd3);
              chk_lat = 1'b0;
            end
            if (tx_eop && chk_gap) begin
              eop_cyc   = cyc;
              gap_armed = 1'b1;
            end
          end else begin
            hold_valid = 1'b1;
            hold_word  = got;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int base;
    int kind;
    repeat (3) @(posedge clk);
    #2;
    check("reset_dval", 32'(tx_dval), 32'd0);
    check("reset_sop",  32'(tx_sop),  32'd0);
    check("reset_eop",  32'(tx_eop),  32'd0);
    check("reset_data", 32'(tx_data), 32'd0);
    check("reset_err",  32'(tx_err),  32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // 6-byte packet, first-byte latency
    chk_lat = 1'b1;
    push_word(2'b10, 16'h0102);
    push_word(2'b00, 16'h0304);
    push_word(2'b01, 16'h0506);
    drain("six_byte");
    check("latency_seen", 32'(chk_lat), 32'd0);

    // 5-byte packet with single-byte eop word
    push_word(2'b10, 16'h1122);
    push_word(2'b00, 16'h3344);
    push_word(2'b11, 16'hAA55);
    drain("five_byte");

    // Same 6-byte packet under 1,0,0 ready pattern
    rdy_mode = 1;
    push_word(2'b10, 16'h0102);
    push_word(2'b00, 16'h0304);
    push_word(2'b01, 16'h0506);
    drain("backpressure");
    rdy_mode = 0;

    // Back-to-back packets, inter-packet gap
    chk_gap = 1'b1;
    push_pkt(6, 1'b1, 0);
    push_pkt(5, 1'b1, 0);
    drain("back_to_back");
    check("gap_seen", 32'(chk_gap), 32'd0);

    // Orphan middle word, then sop inside a packet
    push_word(2'b00, 16'h1234);
    drain("orphan");
    check("err_orphan", 32'(err_seen), 32'(err_exp));
    push_word(2'b10, 16'hA1A2);
    push_word(2'b00, 16'hA3A4);
    push_word(2'b10, 16'hB1B2);
    push_word(2'b01, 16'hB3B4);
    drain("resop");
    check("err_resop", 32'(err_seen), 32'(err_exp));

    // Reset while byte 3 of a 6-byte packet is on the output
    base = acc_bytes;
    push_word(2'b10, 16'hC1C2);
    push_word(2'b00, 16'hC3C4);
    push_word(2'b01, 16'hC5C6);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (acc_bytes >= base + 2) break;
    end
    check("reset_reached_byte3", 32'(acc_bytes - base), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dval",  32'(tx_dval), 32'd0);
    check("midrst_data",  32'(tx_data), 32'd0);
    check("midrst_rdreq", 32'(rdreq),   32'd0);
    pfifo.delete();
    exp_q.delete();
    model_in_pkt = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    push_pkt(6, 1'b1, 0);
    drain("after_reset");

    // Randomized traffic: lengths, ready, underruns, framing faults
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      if (kind == 8) begin
        push_word(($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11),
                  16'($urandom));
      end else if (kind == 9) begin
        push_pkt($urandom_range(3, 12), 1'b0, 4);
      end else begin
        push_pkt($urandom_range(3, 24), 1'b1, 6);
      end
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #2;
      end
    end
    drain("random");
    rdy_mode = 0;
    check("err_total", 32'(err_seen), 32'(err_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_bacdctx.md
# ex_bacdctx

Transmit-side byte-width converter for the slink path, the counterpart of the slink receive converter. It pulls 18-bit framed words from the upstream transmit packet FIFO (read-request/empty interface, 1-cycle read latency). It serializes each word high byte first onto the 8-bit MAC transmit stream, with sop/eop marking and valid/ready backpressure. Single clock domain; it sits between the MM-side transmit PFIFO read port and the MAC transmit byte interface.

## Interface
Parameters:
- IPG_CYCLES, 12: idle cycles inserted after each eop byte (used only when the gap feature is compiled in, 1..255).

Ports:
- clk_125m  input  1  system clock.
- rst_125m  input  1  reset; one clock; reset is asynchronous and active-low.
- mm_slink_empty  input  1  upstream PFIFO empty.
- slink_mm_rdreq  output  1  read request to PFIFO (combinational).
- mm_slink_dval  input  1  read data valid, one cycle after an accepted slink_mm_rdreq.
- mm_slink_data  input  18  word: [17:16] tag, [15:8] first byte, [7:0] second byte.
- mactx_txfifo_rdy  input  1  MAC accepts the current byte.
- mactx_txfifo_dval  output  1  byte valid.
- mactx_txfifo_sop  output  1  first byte of packet.
- mactx_txfifo_eop  output  1  last byte of packet.
- mactx_txfifo_data  output  8  byte.
- slink_tx_err  output  1  one-cycle framing-error pulse.

## Operation
- Tag encoding:
  - 2'b10: sop word, both bytes valid.
  - 2'b00: middle word, both bytes valid.
  - 2'b01: eop word, both bytes valid.
  - 2'b11: eop word, only [15:8] valid.
  - Minimum packet length is 3 bytes, so sop and eop never share a word.
- Word buffer: 2-entry FIFO of received words.
  - outstanding = registered copy of the accepted rdreq.
  - slink_mm_rdreq = !mm_slink_empty && (occupancy + outstanding) < 2.
  - The buffer is written when mm_slink_dval=1.
- Serializer FSM:
  - IDLE: buffer non-empty → load head word → HI.
  - HI: present [15:8].
    - sop=1 if the tag is 10.
    - eop=1 if the tag is 11; on accept, pop the word and go to GAP (or IDLE).
    - Otherwise, on accept, go to LO.
  - LO: present [7:0].
    - eop=1 if the tag is 01.
    - On accept, pop the word. Tag 01 → GAP/IDLE. Otherwise, next word present → HI, else IDLE.
  - GAP: count IPG_CYCLES cycles with dval=0, then go to IDLE.
- Output stage: registered. A byte is held stable while mactx_txfifo_dval=1 and mactx_txfifo_rdy=0. A new byte loads when !dval || rdy.
- Packet tracking: in_pkt is set by an emitted sop byte and cleared by an emitted eop byte.
  - Non-sop word while !in_pkt: word dropped without output, slink_tx_err pulses.
  - Sop word while in_pkt: emitted as a new packet start (no eop for the previous one), slink_tx_err pulses.

## Timing
- Reset values:
  - All outputs 0; slink_mm_rdreq is forced 0 while rst_125m=0.
  - Buffer empty, FSM IDLE, in_pkt=0, outstanding=0.
- Read latency: rdreq asserted in cycle t → data is captured at the end of t+1.
- First-byte latency: mm_slink_empty falls in cycle t with the block idle → mactx_txfifo_dval=1 with sop in cycle t+3.
- Throughput with rdy held 1: one byte per cycle, no bubbles between words, provided the PFIFO stays non-empty.
- Backpressure: rdy=0 for N cycles stalls output for exactly N cycles; no bytes are lost or duplicated.
- Buffer full (occupancy 2): rdreq deasserts. A pop and a write in the same cycle keep the occupancy unchanged.
- PFIFO empty mid-packet: dval drops to 0 (underrun). The packet resumes at the next available word, and no error is flagged.
- Reset mid-packet: output drops immediately. Buffered and outstanding words are discarded.

## Configuration
- EX_BACDCTX_IPG_EN defined: the GAP state inserts IPG_CYCLES idle cycles after every eop byte is accepted.
- Undefined: the GAP state and its counter are removed. After eop, the FSM goes directly to IDLE, and the next sop byte can follow in the next cycle.

## Test plan
- 6-byte packet, words {10,0x0102},{00,0x0304},{01,0x0506}, rdy=1 → bytes 01..06 on consecutive cycles, sop on 01, eop on 06, first byte 3 cycles after empty falls.
- 5-byte packet ending with {11,0xAA55} → last byte 0xAA with eop; 0x55 never emitted.
- Same 6-byte packet with rdy toggling 1,0,0,1… → byte sequence unchanged, each byte held through rdy=0, no rdreq once the buffer is full.
- Back-to-back packets with the macro defined and IPG_CYCLES=12 → exactly 12 dval=0 cycles between eop and the next sop; without the macro, 0 cycles.
- Middle word {00,0x1234} while idle → no output, slink_tx_err high for 1 cycle. Sop word mid-packet → new sop emitted and err pulse.
- Assert reset during byte 3 of a 6-byte packet → outputs 0 immediately; after release, the next packet starts with a clean sop and no stale bytes.
